// File: rtl/tpg_multi.sv
// tpg_multi: programmable-timing video test pattern generator with frame-end shadowed timing.
// Six patterns (bars, grid, ramp, solid, checker, moving box); all video outputs share 1-cycle latency.
module tpg_multi #(
    parameter int CW       = 12,
    parameter int DW       = 8,
    parameter int FW       = 16,
    parameter int CHK_LOG2 = 5,
    parameter int BOX      = 64
) (
    input  logic          I_pxl_clk,
    input  logic          I_rst_n,
    input  logic [2:0]    I_mode,
    input  logic [DW-1:0] I_single_r,
    input  logic [DW-1:0] I_single_g,
    input  logic [DW-1:0] I_single_b,
    input  logic [CW-1:0] I_h_total,
    input  logic [CW-1:0] I_h_sync,
    input  logic [CW-1:0] I_h_bporch,
    input  logic [CW-1:0] I_h_res,
    input  logic [CW-1:0] I_v_total,
    input  logic [CW-1:0] I_v_sync,
    input  logic [CW-1:0] I_v_bporch,
    input  logic [CW-1:0] I_v_res,
    input  logic          I_hs_pol,
    input  logic          I_vs_pol,
    output logic          O_de,
    output logic          O_hs,
    output logic          O_vs,
    output logic [DW-1:0] O_data_r,
    output logic [DW-1:0] O_data_g,
    output logic [DW-1:0] O_data_b,
    output logic [CW-1:0] O_h_cnt,
    output logic [CW-1:0] O_v_cnt,
    output logic [FW-1:0] O_frame
);
    localparam logic [CW-1:0] ONE = CW'(1);
    logic [CW-1:0] h_total_q, h_sync_q, h_bporch_q, h_res_q;
    logic [CW-1:0] v_total_q, v_sync_q, v_bporch_q, v_res_q;
    logic          hs_pol_q, vs_pol_q;
    logic [2:0]    mode_q;
    logic [CW-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d, bx_q, bx_d, by_q, by_d;
    logic [CW-1:0] bar_pos_q, bar_pos_d;
    logic [2:0]    bar_idx_q, bar_idx_d, bi;
    logic [FW-1:0] frame_q;
    logic          de_q, hs_q, vs_q;
    logic [3*DW-1:0] rgb_q, rgb_d, pix, bar_rgb;
    logic          valid, h_wrap, frame_end, load_shadow, load_mode;
    logic          de, hs_act, vs_act, grid_on, in_box, bar_last;
    logic [CW:0]   h_a, v_a, bx_end, by_end;
    logic [CW+1:0] h_end, v_end;
    logic [CW-1:0] x, y, bw;

    always_comb begin
        valid       = (h_total_q != '0) && (v_total_q != '0);
        h_wrap      = valid && (h_cnt_q == h_total_q - ONE);
        frame_end   = h_wrap && (v_cnt_q == v_total_q - ONE);
        load_shadow = !I_rst_n || frame_end || !valid;
        load_mode   = !I_rst_n || h_wrap || !valid;
        h_cnt_d     = (!valid || h_wrap) ? '0 : h_cnt_q + ONE;
        v_cnt_d     = (!valid || frame_end) ? '0 : h_wrap ? v_cnt_q + ONE : v_cnt_q;
        h_a         = {1'b0, h_sync_q} + {1'b0, h_bporch_q};
        v_a         = {1'b0, v_sync_q} + {1'b0, v_bporch_q};
        h_end       = {1'b0, h_a} + {2'b0, h_res_q};
        v_end       = {1'b0, v_a} + {2'b0, v_res_q};
        de          = valid && ({1'b0, h_cnt_q} >= h_a) && ({2'b0, h_cnt_q} < h_end)
                            && ({1'b0, v_cnt_q} >= v_a) && ({2'b0, v_cnt_q} < v_end);
        hs_act      = h_cnt_q < h_sync_q;
        vs_act      = v_cnt_q < v_sync_q;
        x           = h_cnt_q - h_a[CW-1:0];
        y           = v_cnt_q - v_a[CW-1:0];
        // Bars advance with a per-bar pixel counter instead of dividing x by the bar width
        bw          = h_res_q >> 3;
        bar_last    = bar_pos_q == bw - ONE;
        bar_pos_d   = (!de || h_wrap || bar_last) ? '0 : bar_pos_q + ONE;
        bar_idx_d   = (!de || h_wrap) ? 3'd0 : (bar_last && bar_idx_q != 3'd7) ? bar_idx_q + 3'd1 : bar_idx_q;
        bi          = (bw == '0) ? 3'd0 : bar_idx_q;
        bar_rgb     = {{DW{~bi[1]}}, {DW{~bi[2]}}, {DW{~bi[0]}}};
        grid_on     = (x[4:0] == 5'd0) || (y[4:0] == 5'd0) || (x == h_res_q - ONE) || (y == v_res_q - ONE);
        bx_end      = {1'b0, bx_q} + (CW+1)'(BOX);
        by_end      = {1'b0, by_q} + (CW+1)'(BOX);
        in_box      = ({1'b0, x} >= {1'b0, bx_q}) && ({1'b0, x} < bx_end)
                   && ({1'b0, y} >= {1'b0, by_q}) && ({1'b0, y} < by_end);
        bx_d        = !frame_end ? bx_q : ({1'b0, bx_q} + (CW+1)'(1) >= {1'b0, h_res_q}) ? '0 : bx_q + ONE;
        by_d        = !frame_end ? by_q : ({1'b0, by_q} + (CW+1)'(1) >= {1'b0, v_res_q}) ? '0 : by_q + ONE;
        pix         = (mode_q == 3'd0) ? bar_rgb :
                      (mode_q == 3'd1) ? {3*DW{grid_on}} :
                      (mode_q == 3'd2) ? {3{x[DW-1:0]}} :
                      (mode_q == 3'd3) ? {I_single_r, I_single_g, I_single_b} :
                      (mode_q == 3'd4) ? {3*DW{x[CHK_LOG2] ^ y[CHK_LOG2]}} :
                      (mode_q == 3'd5) ? (in_box ? {3*DW{1'b1}} : {{2*DW{1'b0}}, {DW{1'b1}}}) : '0;
        rgb_d       = de ? pix : '0;
    end

    // Shadow timing and mode register: no reset value, they load from the inputs instead
    always_ff @(posedge I_pxl_clk) begin
        if (load_shadow) begin
            h_total_q  <= I_h_total;
            h_sync_q   <= I_h_sync;
            h_bporch_q <= I_h_bporch;
            h_res_q    <= I_h_res;
            v_total_q  <= I_v_total;
            v_sync_q   <= I_v_sync;
            v_bporch_q <= I_v_bporch;
            v_res_q    <= I_v_res;
            hs_pol_q   <= I_hs_pol;
            vs_pol_q   <= I_vs_pol;
        end
        if (load_mode) mode_q <= I_mode;
    end

    always_ff @(posedge I_pxl_clk) begin
        if (!I_rst_n) begin
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            frame_q   <= '0;
            bx_q      <= '0;
            by_q      <= '0;
            bar_pos_q <= '0;
            bar_idx_q <= '0;
            de_q      <= 1'b0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            rgb_q     <= '0;
        end else begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            frame_q   <= frame_end ? frame_q + FW'(1) : frame_q;
            bx_q      <= bx_d;
            by_q      <= by_d;
            bar_pos_q <= bar_pos_d;
            bar_idx_q <= bar_idx_d;
            de_q      <= de;
            hs_q      <= valid && (hs_act ~^ hs_pol_q);
            vs_q      <= valid && (vs_act ~^ vs_pol_q);
            rgb_q     <= rgb_d;
        end
    end

    assign O_de = de_q;
    assign O_hs = hs_q;
    assign O_vs = vs_q;
    assign {O_data_r, O_data_g, O_data_b} = rgb_q;
    assign O_h_cnt = h_cnt_q;
    assign O_v_cnt = v_cnt_q;
    assign O_frame = frame_q;
endmodule

// File: tb/tb_tpg_multi.sv
// tb_tpg_multi: directed vector table plus multi-cycle sequences for tpg_multi.
// Small 20x10 timing, CHK_LOG2=1 and BOX=2 keep every frame short.
module tb_tpg_multi;
    localparam int CW = 12;
    localparam int DW = 8;
    localparam int FW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    mode = 3'd4;
    logic [DW-1:0] sr = 8'h12, sg = 8'h34, sb = 8'h56;
    logic [CW-1:0] h_total = 20, h_sync = 2, h_bporch = 3, h_res = 12;
    logic [CW-1:0] v_total = 10, v_sync = 1, v_bporch = 2, v_res = 6;
    logic          hs_pol = 1'b1, vs_pol = 1'b1;
    logic          O_de, O_hs, O_vs;
    logic [DW-1:0] O_data_r, O_data_g, O_data_b;
    logic [CW-1:0] O_h_cnt, O_v_cnt;
    logic [FW-1:0] O_frame;
    int checks = 0;
    int errors = 0;

    tpg_multi #(.CW(CW), .DW(DW), .FW(FW), .CHK_LOG2(1), .BOX(2)) dut (
        .I_pxl_clk(clk), .I_rst_n(rst_n), .I_mode(mode),
        .I_single_r(sr), .I_single_g(sg), .I_single_b(sb),
        .I_h_total(h_total), .I_h_sync(h_sync), .I_h_bporch(h_bporch), .I_h_res(h_res),
        .I_v_total(v_total), .I_v_sync(v_sync), .I_v_bporch(v_bporch), .I_v_res(v_res),
        .I_hs_pol(hs_pol), .I_vs_pol(vs_pol),
        .O_de(O_de), .O_hs(O_hs), .O_vs(O_vs),
        .O_data_r(O_data_r), .O_data_g(O_data_g), .O_data_b(O_data_b),
        .O_h_cnt(O_h_cnt), .O_v_cnt(O_v_cnt), .O_frame(O_frame)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  mode;
        int          ht;
        int          hr;
        int          h;
        int          v;
        logic        de;
        logic        hs;
        logic        vs;
        logic [23:0] rgb;
    } vec_t;

    vec_t vt[30];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Stops one cycle after the counters show (h,v), so outputs describe that pixel
    task automatic run_to(input int h, input int v);
        int n = 0;
        while (!(O_h_cnt == h && O_v_cnt == v) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL run_to(%0d,%0d): timeout", h, v);
        end
        @(negedge clk);
    endtask

    task automatic check_px(input string name, input int h, input int v, input logic [23:0] exp);
        run_to(h, v);
        chk(name, {O_data_r, O_data_g, O_data_b}, exp);
    endtask

    task automatic wait_frame(input int target);
        int n = 0;
        while (O_frame != target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            checks++;
            errors++;
            $display("FAIL wait_frame(%0d): timeout at %0d", target, O_frame);
        end
    endtask

    initial begin
        int hs_n, vs_n, de_n, first_de, n, bad;
        vt = '{
            '{3'd4, 20, 12,  5, 3, 1'b1, 1'b0, 1'b0, 24'h000000},
            '{3'd4, 20, 12,  7, 3, 1'b1, 1'b0, 1'b0, 24'hFFFFFF},
            '{3'd4, 20, 12,  6, 3, 1'b1, 1'b0, 1'b0, 24'h000000},
            '{3'd4, 20, 12,  7, 5, 1'b1, 1'b0, 1'b0, 24'h000000},
            '{3'd4, 20, 12,  5, 5, 1'b1, 1'b0, 1'b0, 24'hFFFFFF},
            '{3'd4, 20, 12,  1, 0, 1'b0, 1'b1, 1'b1, 24'h000000},
            '{3'd4, 20, 12, 17, 3, 1'b0, 1'b0, 1'b0, 24'h000000},
            '{3'd4, 20, 12, 16, 8, 1'b1, 1'b0, 1'b0, 24'hFFFFFF},
            '{3'd4, 20, 12, 16, 9, 1'b0, 1'b0, 1'b0, 24'h000000},
            '{3'd0, 24, 16,  5, 3, 1'b1, 1'b0, 1'b0, 24'hFFFFFF},
            '{3'd0, 24, 16,  7, 3, 1'b1, 1'b0, 1'b0, 24'hFFFF00},
            '{3'd0, 24, 16,  8, 3, 1'b1, 1'b0, 1'b0, 24'hFFFF00},
            '{3'd0, 24, 16,  9, 3, 1'b1, 1'b0, 1'b0, 24'h00FFFF},
            '{3'd0, 24, 16, 15, 3, 1'b1, 1'b0, 1'b0, 24'hFF0000},
            '{3'd0, 24, 16, 17, 3, 1'b1, 1'b0, 1'b0, 24'h0000FF},
            '{3'd0, 24, 16, 20, 3, 1'b1, 1'b0, 1'b0, 24'h000000},
            '{3'd0, 24,  4,  8, 3, 1'b1, 1'b0, 1'b0, 24'hFFFFFF},
            '{3'd0, 24,  4,  9, 3, 1'b0, 1'b0, 1'b0, 24'h000000},
            '{3'd1, 20, 12,  5, 4, 1'b1, 1'b0, 1'b0, 24'hFFFFFF},
            '{3'd1, 20, 12,  8, 5, 1'b1, 1'b0, 1'b0, 24'h000000},
            '{3'd1, 20, 12, 16, 5, 1'b1, 1'b0, 1'b0, 24'hFFFFFF},
            '{3'd1, 20, 12,  8, 8, 1'b1, 1'b0, 1'b0, 24'hFFFFFF},
            '{3'd2, 20, 12, 12, 4, 1'b1, 1'b0, 1'b0, 24'h070707},
            '{3'd2, 20, 12, 16, 4, 1'b1, 1'b0, 1'b0, 24'h0B0B0B},
            '{3'd3, 20, 12, 10, 6, 1'b1, 1'b0, 1'b0, 24'h123456},
            '{3'd3, 20, 12,  2, 3, 1'b0, 1'b0, 1'b0, 24'h000000},
            '{3'd6, 20, 12, 10, 6, 1'b1, 1'b0, 1'b0, 24'h000000},
            '{3'd5, 20, 12,  6, 4, 1'b1, 1'b0, 1'b0, 24'hFFFFFF},
            '{3'd5, 20, 12,  7, 3, 1'b1, 1'b0, 1'b0, 24'h0000FF},
            '{3'd7, 20, 12, 10, 4, 1'b1, 1'b0, 1'b0, 24'h000000}
        };

        do_reset();
        chk("reset_state", {O_de, O_hs, O_vs, O_data_r, O_data_g, O_data_b, O_h_cnt, O_v_cnt, O_frame}, '0);

        for (int i = 0; i < 30; i++) begin
            mode = vt[i].mode;
            h_total = CW'(vt[i].ht);
            h_res = CW'(vt[i].hr);
            do_reset();
            run_to(vt[i].h, vt[i].v);
            chk($sformatf("vec%0d_de", i), O_de, vt[i].de);
            chk($sformatf("vec%0d_hs", i), O_hs, vt[i].hs);
            chk($sformatf("vec%0d_vs", i), O_vs, vt[i].vs);
            chk($sformatf("vec%0d_rgb", i), {O_data_r, O_data_g, O_data_b}, vt[i].rgb);
        end

        // One full frame of sync/DE statistics
        mode = 3'd4; h_total = 20; h_res = 12;
        do_reset();
        hs_n = 0; vs_n = 0; de_n = 0; first_de = 0;
        for (int j = 1; j <= 200; j++) begin
            @(negedge clk);
            hs_n += int'(O_hs);
            vs_n += int'(O_vs);
            de_n += int'(O_de);
            if (O_de && first_de == 0) first_de = j;
        end
        chk("hs_high_count", hs_n, 20);
        chk("vs_high_count", vs_n, 20);
        chk("de_count", de_n, 72);
        chk("first_de_cycle", first_de, 66);
        chk("frame_after_one", O_frame, 1);

        // Active-low syncs, h_total reprogrammed mid-frame
        hs_pol = 1'b0; vs_pol = 1'b0;
        do_reset();
        n = 0; hs_n = 0; vs_n = 0;
        while (O_frame == 0 && n < 1000) begin
            @(negedge clk);
            n++;
            hs_n += int'(!O_hs);
            vs_n += int'(!O_vs);
            if (n == 50) h_total = 24;
        end
        chk("frame_len_old", n, 200);
        chk("hs_low_count", hs_n, 20);
        chk("vs_low_count", vs_n, 20);
        n = 0;
        while (O_frame == 1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("frame_len_new", n, 240);
        h_total = 20; hs_pol = 1'b1; vs_pol = 1'b1;

        // Mode change mid-line only lands on the next line
        mode = 3'd3;
        do_reset();
        check_px("m3_before", 8, 4, 24'h123456);
        mode = 3'd2;
        check_px("m3_same_line", 12, 4, 24'h123456);
        check_px("m2_next_line", 8, 5, 24'h030303);

        // Moving box across frames, including the bx/by wrap
        mode = 3'd5;
        do_reset();
        check_px("box_f0_origin", 5, 3, 24'hFFFFFF);
        wait_frame(1);
        check_px("box_f1_origin", 5, 3, 24'h0000FF);
        check_px("box_f1_11", 6, 4, 24'hFFFFFF);
        wait_frame(11);
        check_px("box_f11_left", 15, 8, 24'h0000FF);
        check_px("box_f11_clip", 16, 8, 24'hFFFFFF);
        wait_frame(12);
        chk("frame_12", O_frame, 12);
        check_px("box_f12_origin", 5, 3, 24'hFFFFFF);
        check_px("box_f12_x2", 7, 3, 24'h0000FF);

        // Single-cycle reset mid-frame
        mode = 3'd3;
        do_reset();
        wait_frame(1);
        run_to(8, 4);
        chk("pre_reset_de", O_de, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_reset_zero", {O_de, O_hs, O_vs, O_data_r, O_data_g, O_data_b, O_h_cnt, O_v_cnt, O_frame}, '0);

        // Zero h_total holds everything at 0 until a valid total arrives
        h_total = 0;
        do_reset();
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if ({O_de, O_hs, O_vs, O_data_r, O_data_g, O_data_b, O_h_cnt, O_v_cnt, O_frame} != '0) bad++;
        end
        chk("zero_total_hold", bad, 0);
        h_total = 20;
        repeat (5) @(negedge clk);
        chk("restart_hcnt", O_h_cnt, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tpg_multi.md
Name: tpg_multi

Overview:
- Parametrised successor to the fixed 8-bit test pattern generator feeding the DVI TX path.
- Generates programmable video timing (HS/VS/DE), raw pixel counters and a frame counter.
- Provides six patterns, including an animated one.
- Timing and polarity inputs go through shadow registers, latched only at frame end, so live reprogramming never tears a frame.

Parameters:
- CW, 12: width of the timing inputs and of the h/v counters.
- DW, 8: bits per colour channel.
- FW, 16: frame counter width.
- CHK_LOG2, 5: checkerboard cell size is 2^CHK_LOG2 pixels.
- BOX, 64: moving-box side length in pixels.

Ports:
- I_pxl_clk  in  1  pixel clock; the only clock.
- I_rst_n  in  1  reset; synchronous, active-low.
- I_mode  in  3  pattern select.
- I_single_r / I_single_g / I_single_b  in  DW each  colour for mode 3.
- I_h_total, I_h_sync, I_h_bporch, I_h_res  in  CW each  horizontal timing.
- I_v_total, I_v_sync, I_v_bporch, I_v_res  in  CW each  vertical timing.
- I_hs_pol / I_vs_pol  in  1 each  1 = active-high sync, 0 = active-low.
- O_de / O_hs / O_vs  out  1 each  registered video controls.
- O_data_r / O_data_g / O_data_b  out  DW each  registered pixel data.
- O_h_cnt / O_v_cnt  out  CW each  raw counters, not delayed.
- O_frame  out  FW  completed-frame count, wraps.

Behaviour:
- Reset (I_rst_n=0 at a clock edge):
  - h_cnt, v_cnt, O_frame, box position, O_de, O_hs, O_vs and O_data_* all go to 0.
  - Shadow timing/polarity registers load from the inputs on every reset cycle.
  - Reset mid-frame aborts the frame immediately, with no completion.
- Counters:
  - h_cnt counts 0..h_total-1 and wraps.
  - On the h wrap, v_cnt increments, wrapping at v_total-1.
  - frame_end = (h_cnt==h_total-1 && v_cnt==v_total-1).
  - On frame_end: O_frame+1, and the shadow registers reload from the inputs. The new values govern the cycle where h_cnt=v_cnt=0.
  - If shadow h_total or v_total is 0: counters hold at 0, O_de=O_hs=O_vs=0 and data=0. The shadow keeps reloading every cycle until both are nonzero.
- Timing decode (all shadow values):
  - hs_act = h_cnt < h_sync.
  - vs_act = v_cnt < v_sync.
  - hA = h_sync + h_bporch; vA = v_sync + v_bporch.
  - de = (hA <= h_cnt < hA + h_res) && (vA <= v_cnt < vA + v_res).
  - O_hs = hs_act XNOR hs_pol; O_vs = vs_act XNOR vs_pol.
  - Windows that exceed the total are not clamped; DE is simply truncated.
- Latency: O_de/O_hs/O_vs/O_data_* correspond to the counter values of the previous cycle, i.e. exactly 1 clock, all aligned.
- Mode register: I_mode is sampled at every h wrap and at reset release; a mode change takes effect on the next line.
- Active coordinates: x = h_cnt - hA, y = v_cnt - vA, both CW-bit and valid only while de. Outside de, data=0.
- Patterns (full = all-ones DW):
  - 0, colour bars: bar width bw = h_res>>3, bar index = min(x/bw, 7). Use an incremental counter, not a divider. Order: white, yellow, cyan, green, magenta, red, blue, black. If bw=0, the whole line is white.
  - 1, grid: white if x[4:0]==0, y[4:0]==0, x==h_res-1 or y==v_res-1; else black.
  - 2, grey ramp: r=g=b=x[DW-1:0], wrapping every 2^DW pixels.
  - 3, single colour: I_single_r/g/b, sampled live.
  - 4, checkerboard: white if x[CHK_LOG2] XOR y[CHK_LOG2]; else black.
  - 5, moving box:
    - White where bx <= x < bx+BOX and by <= y < by+BOX; elsewhere blue (0,0,full).
    - bx and by increment by 1 on each frame_end.
    - bx wraps to 0 when bx+1 >= h_res; by wraps to 0 when by+1 >= v_res.
    - The box is clipped at the right and bottom edges, not wrapped.
  - 6, 7: black.

Test Plan:
- Small timing (h: total 20, sync 2, bporch 3, res 12; v: total 10, sync 1, bporch 2, res 6; pol 1,1), mode 4, CHK_LOG2=1 -> O_hs high 2 of every 20 clocks, O_vs high for 20 clocks per 200, O_de high 12×6 per frame, first DE exactly 1 clock after h_cnt=5,v_cnt=3, checker flips every 2 px.
- Same timing with pol 0,0, then switch I_h_total to 24 mid-frame -> current frame stays 200 clocks; the next frame is 240 clocks; O_hs active-low.
- Mode 0, h_res=16 -> bars of 2 px in order white..black (e.g. x=2,3 -> (full,full,0)); h_res=4 -> all white.
- Mode 5, BOX=2, h_res=12 -> box starts at x=0,y=0, moves +1/+1 each frame, bx wraps to 0 after 11 frames, O_frame counts 0..N.
- Mode toggled 3→2 mid-line -> data changes only on the next line; mode 3 outputs I_single values, mode 2 ramp r=x.
- Assert I_rst_n=0 for 1 cycle mid-frame -> next edge: all outputs 0, O_h_cnt=O_v_cnt=O_frame=0. Also h_total=0 -> all outputs held at 0.
